// File: rtl/line_buffer_v_3_uint10.sv
// line_buffer_v_3_uint10: 3x1 vertical window builder for a raster uint10 stream.
// Two ping-pong row RAMs; replicates top/bottom edges and flushes the last row.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous reset, active low
//   data_i    input pixel (uint10)
//   col_i     input pixel column, 0..WIDTH-1
//   row_i     input pixel row, 0..HEIGHT-1
//   valid_i   input pixel valid
//   ready_o   input accepted when valid_i && ready_o
//   window_o  [0] top, [1] centre, [2] bottom
//   col_o     column of window centre
//   row_o     row of window centre
//   valid_o   one-cycle window strobe, no backpressure
module line_buffer_v_3_uint10 #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [9:0]  data_i,
   input  logic [15:0] col_i,
   input  logic [15:0] row_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [9:0]  window_o [3][1],
   output logic [15:0] col_o,
   output logic [15:0] row_o,
   output logic        valid_o
);

   localparam int ADDR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(WIDTH - 1);
   localparam logic [15:0] LAST_COL16 = 16'(WIDTH - 1);
   localparam logic [15:0] LAST_ROW16 = 16'(HEIGHT - 1);
   // Buffer holding the bottom image row once the frame is complete
   localparam logic BOT_SEL = LAST_ROW16[0];

   typedef enum logic {
      ST_STREAM,
      ST_FLUSH
   } state_t;

   // How the registered read data maps onto the window
   typedef enum logic [1:0] {
      K_ROW1,
      K_ROWN,
      K_FLUSH
   } kind_t;

   state_t state_q, state_d;
   kind_t  kind_q, kind_d;

   logic [ADDR_W-1:0] f_q, f_d;
   logic              vld_q, vld_d;
   logic              sel_q, sel_d;
   logic [9:0]        pix_q, pix_d;
   logic [15:0]       col_q, col_d;
   logic [15:0]       row_q, row_d;
   logic [9:0]        rd0_q, rd1_q;

   logic [9:0] mem0_q [WIDTH];
   logic [9:0] mem1_q [WIDTH];

   logic [ADDR_W-1:0] addr;
   logic              we0, we1, re;
   logic              xfer;
   logic              last_px;

   assign ready_o = (state_q == ST_STREAM);
   assign xfer    = valid_i && ready_o;
   assign last_px = (row_i == LAST_ROW16) && (col_i == LAST_COL16);

   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      kind_d  = kind_q;
      vld_d   = 1'b0;
      sel_d   = sel_q;
      pix_d   = pix_q;
      col_d   = col_q;
      row_d   = row_q;
      addr    = col_i[ADDR_W-1:0];
      we0     = 1'b0;
      we1     = 1'b0;
      re      = 1'b0;
      unique case (state_q)
         ST_STREAM: begin
            if (xfer) begin
               re  = 1'b1;
               we0 = ~row_i[0];
               we1 = row_i[0];
               // Row 0 only fills the buffer; no window yet
               if (row_i != 16'd0) begin
                  vld_d  = 1'b1;
                  sel_d  = row_i[0];
                  pix_d  = data_i;
                  col_d  = col_i;
                  row_d  = row_i - 16'd1;
                  kind_d = (row_i == 16'd1) ? K_ROW1 : K_ROWN;
               end
               if (last_px) begin
                  state_d = ST_FLUSH;
                  f_d     = '0;
               end
            end
         end
         ST_FLUSH: begin
            addr   = f_q;
            re     = 1'b1;
            vld_d  = 1'b1;
            sel_d  = BOT_SEL;
            kind_d = K_FLUSH;
            col_d  = 16'(f_q);
            row_d  = LAST_ROW16;
            if (f_q == LAST_COL) begin
               state_d = ST_STREAM;
               f_d     = '0;
            end else begin
               f_d = f_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = ST_STREAM;
         end
      endcase
   end

   // Row storage; not reset, every frame overwrites it
   always_ff @(posedge clk_i) begin
      if (we0) mem0_q[addr] <= data_i;
      if (we1) mem1_q[addr] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_STREAM;
         f_q     <= '0;
         kind_q  <= K_ROWN;
         vld_q   <= 1'b0;
         sel_q   <= 1'b0;
         pix_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         kind_q  <= kind_d;
         vld_q   <= vld_d;
         sel_q   <= sel_d;
         pix_q   <= pix_d;
         col_q   <= col_d;
         row_q   <= row_d;
         // Read-before-write: old contents land here
         if (re) begin
            rd0_q <= mem0_q[addr];
            rd1_q <= mem1_q[addr];
         end
      end
   end

   // cur: buffer of the row parity (r-2 while streaming, H-1 when flushing)
   // prv: the other buffer (always the row just above)
   logic [9:0] cur, prv;

   assign cur = sel_q ? rd1_q : rd0_q;
   assign prv = sel_q ? rd0_q : rd1_q;

   always_comb begin
      window_o[0][0] = prv;
      window_o[1][0] = prv;
      window_o[2][0] = pix_q;
      unique case (kind_q)
         K_ROW1: begin
            window_o[0][0] = prv;
            window_o[1][0] = prv;
            window_o[2][0] = pix_q;
         end
         K_ROWN: begin
            window_o[0][0] = cur;
            window_o[1][0] = prv;
            window_o[2][0] = pix_q;
         end
         K_FLUSH: begin
            window_o[0][0] = prv;
            window_o[1][0] = cur;
            window_o[2][0] = cur;
         end
         default: begin
            window_o[0][0] = prv;
         end
      endcase
   end

   assign col_o   = col_q;
   assign row_o   = row_q;
   assign valid_o = vld_q;

endmodule
